turn_input_conditioner: RTL and testbench

- Front end for the tail-light FSM: turns raw, asynchronous, bouncing left/right turn buttons into clean request levels `l` and `r`.
- The tail-light FSM samples its inputs only on its slow enable strobe. This block therefore holds each debounced press as a pending request until that strobe (`tick`) consumes it.
- Sits between board buttons and the FSM, in the same clock domain; `tick` is wired to the FSM's divided clock-enable.

---
 rtl/turn_pkg.sv | 15 +
 rtl/btn_debounce.sv | 95 +++++++++
 rtl/turn_input_conditioner.sv | 88 ++++++++
 tb/tb_turn_input_conditioner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the turn-signal input conditioner.
//   chan_state_e            : per-button debounce state (2-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES : stable-cycle count for a board clock of ~50-100 MHz
package turn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } chan_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: synchronizer, press/release debounce FSM and counter.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   btn_i   in  raw asynchronous button level
//   press_o out one-cycle pulse when a press is accepted (registered)
//   held_o  out debounced button level (high in HELD and REL_CHK)
module btn_debounce
  import turn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o,
  output logic held_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_x;

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Only the last synchronizer stage is safe to use; earlier stages may be metastable.
  assign s_x = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_x) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_CHK: begin
        if (!s_x) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s_x) begin
          state_d = REL_CHK;
          cnt_d   = CNT_ONE;
        end
      end
      REL_CHK: begin
        // Returning high here is a release glitch, not a new press.
        if (s_x) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
  assign held_o  = (state_q == HELD) || (state_q == REL_CHK);

endmodule

// File: rtl/turn_input_conditioner.sv
// Conditions the left/right turn buttons for the tail-light FSM: debounces each
// button and holds an accepted press as a pending request until `tick` consumes it.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   btn_l   in  raw left button (async)
//   btn_r   in  raw right button (async)
//   tick    in  one-cycle consume strobe from the FSM clock divider
//   l, r    out pending left/right requests (registered)
//   hazard  out both requests pending
//   l_held  out debounced left level (registered)
//   r_held  out debounced right level (registered)
module turn_input_conditioner
  import turn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_l,
  input  logic btn_r,
  input  logic tick,
  output logic l,
  output logic r,
  output logic hazard,
  output logic l_held,
  output logic r_held
);

  logic press_l, press_r;
  logic held_l, held_r;
  logic l_q, l_d, r_q, r_d;
  logic l_held_q, r_held_q;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_left (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_l),
    .press_o(press_l),
    .held_o (held_l)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_right (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_r),
    .press_o(press_r),
    .held_o (held_r)
  );

  // A press wins over a simultaneous tick so the new request is never lost.
  always_comb begin
    l_d = l_q;
    r_d = r_q;
    if (press_l)   l_d = 1'b1;
    else if (tick) l_d = 1'b0;
    if (press_r)   r_d = 1'b1;
    else if (tick) r_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q      <= 1'b0;
      r_q      <= 1'b0;
      l_held_q <= 1'b0;
      r_held_q <= 1'b0;
    end else begin
      l_q      <= l_d;
      r_q      <= r_d;
      l_held_q <= held_l;
      r_held_q <= held_r;
    end
  end

  assign l      = l_q;
  assign r      = r_q;
  assign hazard = l_q & r_q;
  assign l_held = l_held_q;
  assign r_held = r_held_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Self-checking bench for turn_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Reference model: each button's synchronized sample stream is a delay line; the
// debounced level flips after DEBOUNCE_CYCLES+1 consecutive samples that disagree
// with it. A rising flip is a press, which reaches the request output one edge later.
module tb_turn_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB + 1;

  logic clk = 1'b0;
  logic rst, btn_l, btn_r, tick;
  logic l, r, hazard, l_held, r_held;

  always #5 clk = ~clk;

  turn_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_l (btn_l),
    .btn_r (btn_r),
    .tick  (tick),
    .l     (l),
    .r     (r),
    .hazard(hazard),
    .l_held(l_held),
    .r_held(r_held)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit tick_auto = 1'b0;
  bit man_tick  = 1'b0;

  // Model state, index 0 = left, 1 = right.
  bit hist[2][$];
  bit lvl_m[2];
  int run_m[2];
  bit press_m[2];
  bit req_m[2];
  bit held_m[2];

  int rises, hold_l, hold_r;
  bit prev_l, held_seen, held_drop, seen_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      hist[c].delete();
      for (int k = 0; k < SYNC; k++) hist[c].push_back(1'b0);
      lvl_m[c]   = 1'b0;
      run_m[c]   = 0;
      press_m[c] = 1'b0;
      req_m[c]   = 1'b0;
      held_m[c]  = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit raw_l, input bit raw_r, input bit tk);
    for (int c = 0; c < 2; c++) begin
      bit raw, seen;
      raw = (c == 0) ? raw_l : raw_r;
      req_m[c]  = press_m[c] ? 1'b1 : (tk ? 1'b0 : req_m[c]);
      held_m[c] = lvl_m[c];
      seen = hist[c].pop_front();
      hist[c].push_back(raw);
      press_m[c] = 1'b0;
      if (seen != lvl_m[c]) begin
        run_m[c]++;
        if (run_m[c] == DEB + 1) begin
          lvl_m[c]   = ~lvl_m[c];
          run_m[c]   = 0;
          press_m[c] = lvl_m[c];
        end
      end else begin
        run_m[c] = 0;
      end
    end
  endfunction

  // One clock: drive tick, let the edge happen, advance the model, compare at negedge.
  task automatic step();
    tick = man_tick || (tick_auto && (cyc % 16 == 15));
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(btn_l, btn_r, tick);
    @(negedge clk);
    cyc++;
    check("l",      l,      req_m[0]);
    check("r",      r,      req_m[1]);
    check("hazard", hazard, req_m[0] & req_m[1]);
    check("l_held", l_held, held_m[0]);
    check("r_held", r_held, held_m[1]);
  endtask

  task automatic pulse_tick();
    man_tick = 1'b1;
    step();
    man_tick = 1'b0;
  endtask

  task automatic settle();
    btn_l = 1'b0;
    btn_r = 1'b0;
    repeat (12) step();
    pulse_tick();
    repeat (2) step();
  endtask

  // Counts edges from the first one with btn_l high until l rises (bounded).
  task automatic measure(input string tag);
    int n;
    n = -1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (l === 1'b1) begin
        n = i;
        break;
      end
    end
    check(tag, n, LAT);
  endtask

  initial begin
    rst   = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick  = 1'b0;
    model_reset();
    @(negedge clk);
    step();
    step();
    check("reset_outs", {l, r, hazard, l_held, r_held}, 5'b0);
    rst = 1'b0;
    repeat (3) step();

    // Clean press: latency, single request, cleared by tick, no auto-repeat.
    btn_l = 1'b1;
    measure("lat_clean");
    check("lat_held", l_held, 1'b1);
    repeat (5) step();
    check("clean_hold_req", l, 1'b1);
    pulse_tick();
    check("clean_cleared", l, 1'b0);
    repeat (10) step();
    check("clean_no_repeat", l, 1'b0);
    settle();

    // Bounce rejection on the right button.
    seen_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      btn_r = ((i / 2) % 2) == 0;
      step();
      seen_r |= (r | r_held);
    end
    btn_r = 1'b0;
    repeat (10) begin
      step();
      seen_r |= (r | r_held);
    end
    check("bounce_reject", seen_r, 1'b0);
    btn_r = 1'b1;
    repeat (10) step();
    check("bounce_then_hold", r, 1'b1);
    settle();

    // Press accepted in the same cycle as a tick.
    btn_l = 1'b1;
    repeat (LAT) step();
    pulse_tick();
    check("collide_kept", l, 1'b1);
    repeat (3) step();
    check("collide_still", l, 1'b1);
    pulse_tick();
    check("collide_cleared", l, 1'b0);
    settle();

    // Hazard: both buttons together.
    btn_l = 1'b1;
    btn_r = 1'b1;
    repeat (LAT + 1) step();
    check("hazard_set", {l, r, hazard}, 3'b111);
    pulse_tick();
    check("hazard_clear", {l, r, hazard}, 3'b000);
    settle();

    // Held button with a short release glitch.
    tick_auto = 1'b1;
    rises     = 0;
    prev_l    = l;
    held_seen = 1'b0;
    held_drop = 1'b0;
    for (int i = 0; i < 40; i++) begin
      btn_l = !(i == 20 || i == 21);
      step();
      if (l && !prev_l) rises++;
      prev_l = l;
      if (held_seen && !l_held) held_drop = 1'b1;
      if (l_held) held_seen = 1'b1;
    end
    check("glitch_one_req", rises, 1);
    check("glitch_held_kept", held_drop, 1'b0);
    tick_auto = 1'b0;
    settle();

    // Reset during debounce, then with a request pending.
    btn_l = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_chk", {l, r, hazard, l_held, r_held}, 5'b0);
    measure("lat_after_rst1");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_pending", {l, r, hazard, l_held, r_held}, 5'b0);
    measure("lat_after_rst2");
    settle();

    // Randomized traffic against the model.
    hold_l = 0;
    hold_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold_l == 0) begin
        btn_l  = 1'($urandom_range(0, 1));
        hold_l = $urandom_range(1, 12);
      end
      if (hold_r == 0) begin
        btn_r  = 1'($urandom_range(0, 1));
        hold_r = $urandom_range(1, 12);
      end
      man_tick = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step();
      hold_l--;
      hold_r--;
    end
    man_tick = 1'b0;
    rst      = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
